// File: rtl/regfile_mp_if.sv
// Decode-stage register file bus: read ports, writeback, issue and scoreboard view.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] readreg;
  logic [NUM_RD*DATA_W-1:0] readdata;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     regwrite;
  logic [ADDR_W-1:0]        writereg;
  logic [DATA_W-1:0]        writedata;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_reg;
  logic [(2**ADDR_W)-1:0]   busy_vec;

  modport master (
    output readreg, regwrite, writereg, writedata, issue_valid, issue_reg,
    input  readdata, rd_busy, busy_vec
  );

  modport slave (
    input  readreg, regwrite, writereg, writedata, issue_valid, issue_reg,
    output readdata, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-through bypass, hardwired r0
// and a pending-write scoreboard for the decode-stage hazard unit.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic                     wr_zero_c;
  logic                     iss_zero_c;
  logic [NUM_RD*DATA_W-1:0] readdata_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  assign wr_zero_c  = (ZERO_REG != 0) && (bus.writereg == '0);
  assign iss_zero_c = (ZERO_REG != 0) && (bus.issue_reg == '0);

  // Next array/scoreboard state; the issue is applied last so a new producer wins.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (bus.regwrite && !wr_zero_c) begin
      mem_d[bus.writereg] = bus.writedata;
    end
    if (bus.regwrite) begin
      busy_d[bus.writereg] = 1'b0;
    end
    if (bus.issue_valid && !iss_zero_c) begin
      busy_d[bus.issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports; the bypass is held off while in reset.
  always_comb begin
    logic [ADDR_W-1:0] idx;
    logic              hit;
    logic              zero;
    idx        = '0;
    hit        = 1'b0;
    zero       = 1'b0;
    readdata_c = '0;
    rd_busy_c  = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      idx  = bus.readreg[i*ADDR_W +: ADDR_W];
      zero = (ZERO_REG != 0) && (idx == '0);
      hit  = (BYPASS != 0) && rst_n && bus.regwrite && (bus.writereg == idx) && !zero;
      if (zero) begin
        readdata_c[i*DATA_W +: DATA_W] = '0;
      end else if (hit) begin
        readdata_c[i*DATA_W +: DATA_W] = bus.writedata;
      end else begin
        readdata_c[i*DATA_W +: DATA_W] = mem_q[idx];
      end
      rd_busy_c[i] = busy_q[idx] && !hit;
    end
  end

  assign bus.readdata = readdata_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array/scoreboard reference model.
module tb_regfile_mp;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) b1 ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) b0 ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));

  assign b0.readreg     = b1.readreg;
  assign b0.regwrite    = b1.regwrite;
  assign b0.writereg    = b1.writereg;
  assign b0.writedata   = b1.writedata;
  assign b0.issue_valid = b1.issue_valid;
  assign b0.issue_reg   = b1.issue_reg;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  function automatic logic [31:0] exp_data(input bit byp, input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (byp && rst_n && b1.regwrite && b1.writereg == idx) return b1.writedata;
    return m_mem[idx];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] idx);
    if (idx == 5'd0) return 1'b0;
    if (byp && rst_n && b1.regwrite && b1.writereg == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  function automatic logic [4:0] rnd_idx();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 5));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_mem[k] = 32'h0;
    m_busy = 32'h0;
  endtask

  task automatic idle();
    b1.regwrite    = 1'b0;
    b1.writereg    = 5'd0;
    b1.writedata   = 32'h0;
    b1.issue_valid = 1'b0;
    b1.issue_reg   = 5'd0;
  endtask

  task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2);
    b1.readreg = {p2, p1, p0};
  endtask

  task automatic drive_wr(input logic [4:0] r, input logic [31:0] d);
    b1.regwrite  = 1'b1;
    b1.writereg  = r;
    b1.writedata = d;
  endtask

  // Advance one clock edge, applying the architectural effect of the current inputs.
  task automatic tick();
    if (rst_n) begin
      if (b1.regwrite && b1.writereg != 5'd0) m_mem[b1.writereg] = b1.writedata;
      if (b1.regwrite) m_busy[b1.writereg] = 1'b0;
      if (b1.issue_valid && b1.issue_reg != 5'd0) m_busy[b1.issue_reg] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    set_rd(5, 6, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b1.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy_vec got=%h exp=0", b1.busy_vec); end
    checks++; if (b1.readdata !== 96'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", b1.readdata); end
    checks++; if (b1.rd_busy !== 3'b0) begin errors++; $display("FAIL reset_rd_busy got=%b exp=0", b1.rd_busy); end
    rst_n = 1'b1;
    drive_wr(5, 32'h1234);
    tick();
    idle();
    #1;
    checks++; if (b1.readdata[31:0] !== 32'h1234) begin errors++; $display("FAIL reset_preload got=%h exp=1234", b1.readdata[31:0]); end
    drive_wr(6, 32'hBEEF);
    b1.issue_valid = 1'b1;
    b1.issue_reg   = 5'd6;
    rst_n = 1'b0;
    #1;
    checks++; if (b1.readdata[31:0] !== 32'h0) begin errors++; $display("FAIL reset_async_r5 got=%h exp=0", b1.readdata[31:0]); end
    checks++; if (b1.readdata[63:32] !== 32'h0) begin errors++; $display("FAIL reset_no_bypass got=%h exp=0", b1.readdata[63:32]); end
    checks++; if (b1.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_async_busy got=%h exp=0", b1.busy_vec); end
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++; if (b1.readdata[63:32] !== 32'h0) begin errors++; $display("FAIL reset_write_ignored got=%h exp=0", b1.readdata[63:32]); end
    checks++; if (b1.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_issue_ignored got=%h exp=0", b1.busy_vec); end
  endtask

  task automatic test_write_read();
    idle();
    set_rd(7, 3, 31);
    drive_wr(7, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    checks++; if (b1.readdata[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_p0 got=%h exp=deadbeef", b1.readdata[31:0]); end
    checks++; if (b0.readdata[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_p0_nobyp got=%h exp=deadbeef", b0.readdata[31:0]); end
    checks++; if (b1.readdata[63:32] !== 32'h0) begin errors++; $display("FAIL wr_rd_p1 got=%h exp=0", b1.readdata[63:32]); end
    checks++; if (b1.readdata[95:64] !== 32'h0) begin errors++; $display("FAIL wr_rd_p2 got=%h exp=0", b1.readdata[95:64]); end
  endtask

  task automatic test_bypass();
    idle();
    set_rd(9, 9, 7);
    drive_wr(9, 32'hFFFFFFF6);
    #1;
    checks++; if (b1.readdata[31:0] !== 32'hFFFFFFF6) begin errors++; $display("FAIL bypass_p0 got=%h exp=fffffff6", b1.readdata[31:0]); end
    checks++; if (b1.readdata[63:32] !== 32'hFFFFFFF6) begin errors++; $display("FAIL bypass_p1 got=%h exp=fffffff6", b1.readdata[63:32]); end
    checks++; if (b0.readdata[31:0] !== 32'h0) begin errors++; $display("FAIL nobypass_old got=%h exp=0", b0.readdata[31:0]); end
    checks++; if (b1.readdata[95:64] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_other_port got=%h exp=deadbeef", b1.readdata[95:64]); end
    tick();
    idle();
    #1;
    checks++; if (b0.readdata[31:0] !== 32'hFFFFFFF6) begin errors++; $display("FAIL nobypass_after got=%h exp=fffffff6", b0.readdata[31:0]); end
  endtask

  task automatic test_zero_reg();
    idle();
    set_rd(0, 0, 0);
    drive_wr(0, 32'h55);
    b1.issue_valid = 1'b1;
    b1.issue_reg   = 5'd0;
    #1;
    checks++; if (b1.readdata !== 96'h0) begin errors++; $display("FAIL zero_bypass got=%h exp=0", b1.readdata); end
    tick();
    idle();
    #1;
    checks++; if (b1.readdata !== 96'h0) begin errors++; $display("FAIL zero_read got=%h exp=0", b1.readdata); end
    checks++; if (b0.readdata !== 96'h0) begin errors++; $display("FAIL zero_read_nobyp got=%h exp=0", b0.readdata); end
    checks++; if (b1.busy_vec[0] !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", b1.busy_vec[0]); end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd(4, 5, 4);
    b1.issue_valid = 1'b1;
    b1.issue_reg   = 5'd4;
    tick();
    idle();
    #1;
    checks++; if (b1.rd_busy !== 3'b101) begin errors++; $display("FAIL sb_issue got=%b exp=101", b1.rd_busy); end
    checks++; if (b0.rd_busy !== 3'b101) begin errors++; $display("FAIL sb_issue_nobyp got=%b exp=101", b0.rd_busy); end
    tick();
    drive_wr(4, 32'h10);
    #1;
    checks++; if (b1.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_wb_mask got=%b exp=0", b1.rd_busy[0]); end
    checks++; if (b1.readdata[31:0] !== 32'h10) begin errors++; $display("FAIL sb_wb_data got=%h exp=10", b1.readdata[31:0]); end
    checks++; if (b0.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_wb_nobyp got=%b exp=1", b0.rd_busy[0]); end
    tick();
    idle();
    #1;
    checks++; if (b0.rd_busy !== 3'b000) begin errors++; $display("FAIL sb_clear got=%b exp=000", b0.rd_busy); end
    checks++; if (b1.busy_vec !== 32'h0) begin errors++; $display("FAIL sb_clear_vec got=%h exp=0", b1.busy_vec); end
    b1.issue_valid = 1'b1;
    b1.issue_reg   = 5'd4;
    tick();
    drive_wr(4, 32'h20);
    #1;
    checks++; if (b0.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_same_pre got=%b exp=1", b0.rd_busy[0]); end
    tick();
    idle();
    #1;
    checks++; if (b1.busy_vec[4] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%b exp=1", b1.busy_vec[4]); end
    checks++; if (b1.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins_rd got=%b exp=1", b1.rd_busy[0]); end
    checks++; if (b1.readdata[31:0] !== 32'h20) begin errors++; $display("FAIL sb_same_data got=%h exp=20", b1.readdata[31:0]); end
    drive_wr(4, 32'h20);
    tick();
    idle();
  endtask

  task automatic test_multiport();
    idle();
    drive_wr(12, 32'hA5A5A5A5);
    tick();
    drive_wr(31, 32'h31313131);
    tick();
    idle();
    set_rd(12, 12, 12);
    #1;
    checks++; if (b1.readdata !== {3{32'hA5A5A5A5}}) begin errors++; $display("FAIL mp_same got=%h exp=a5a5a5a5 x3", b1.readdata); end
    set_rd(12, 12, 31);
    #1;
    checks++; if (b1.readdata[95:64] !== 32'h31313131) begin errors++; $display("FAIL mp_p2_r31 got=%h exp=31313131", b1.readdata[95:64]); end
    checks++; if (b1.readdata[63:32] !== 32'hA5A5A5A5) begin errors++; $display("FAIL mp_p1_r12 got=%h exp=a5a5a5a5", b1.readdata[63:32]); end
  endtask

  task automatic test_random();
    logic [4:0] idx;
    for (int n = 0; n < 400; n++) begin
      b1.regwrite    = ($urandom_range(0, 1) == 1);
      b1.writereg    = rnd_idx();
      b1.writedata   = $urandom;
      b1.issue_valid = ($urandom_range(0, 2) != 0);
      b1.issue_reg   = rnd_idx();
      set_rd(rnd_idx(), rnd_idx(), rnd_idx());
      #1;
      for (int i = 0; i < 3; i++) begin
        idx = b1.readreg[i*5 +: 5];
        checks++;
        if (b1.readdata[i*32 +: 32] !== exp_data(1'b1, idx)) begin
          errors++; $display("FAIL rnd_data_byp n=%0d p=%0d r=%0d got=%h exp=%h", n, i, idx, b1.readdata[i*32 +: 32], exp_data(1'b1, idx));
        end
        checks++;
        if (b0.readdata[i*32 +: 32] !== exp_data(1'b0, idx)) begin
          errors++; $display("FAIL rnd_data_nobyp n=%0d p=%0d r=%0d got=%h exp=%h", n, i, idx, b0.readdata[i*32 +: 32], exp_data(1'b0, idx));
        end
        checks++;
        if (b1.rd_busy[i] !== exp_busy(1'b1, idx) || b0.rd_busy[i] !== exp_busy(1'b0, idx)) begin
          errors++; $display("FAIL rnd_rd_busy n=%0d p=%0d r=%0d got=%b/%b exp=%b/%b", n, i, idx, b1.rd_busy[i], b0.rd_busy[i], exp_busy(1'b1, idx), exp_busy(1'b0, idx));
        end
      end
      checks++;
      if (b1.busy_vec !== m_busy) begin errors++; $display("FAIL rnd_busy_vec n=%0d got=%h exp=%h", n, b1.busy_vec, m_busy); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_multiport();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
